// File: rtl/apb_cfg_master_pkg.sv
// Shared types and constants for the single-outstanding APB configuration master.
package apb_cfg_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    localparam logic [31:0] APB_TIMEOUT_RDATA = 32'hDEAD_0B0B;

    // Request addresses are carried at full 32 bits; the master truncates to its bus width.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
    } apb_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } apb_rsp_t;

    // Completed transfer: writes never leak bus read data back to the requester.
    function automatic apb_rsp_t apb_done_rsp(input logic write, input logic [31:0] prdata,
                                              input logic pslverr);
        apb_rsp_t rsp_v;
        rsp_v.rdata   = write ? 32'h0000_0000 : prdata;
        rsp_v.err     = pslverr;
        rsp_v.timeout = 1'b0;
        return rsp_v;
    endfunction

    function automatic apb_rsp_t apb_timeout_rsp();
        apb_rsp_t rsp_v;
        rsp_v.rdata   = APB_TIMEOUT_RDATA;
        rsp_v.err     = 1'b1;
        rsp_v.timeout = 1'b1;
        return rsp_v;
    endfunction

endpackage

// File: rtl/apb_cfg_master_if.sv
// APB bus bundle between the configuration master and its peripheral slaves.
interface apb_cfg_master_if #(
    parameter int APB_ADDR_WIDTH = 12
) ();

    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_cfg_master.sv
// Single-outstanding APB initiator: valid/ready request in, SETUP/ACCESS on APB,
// valid/ready response out, with an ACCESS-phase stall timeout.
module apb_cfg_master
    import apb_cfg_master_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]               req_wdata_i,
    input  logic                      req_write_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    apb_cfg_master_if.master          apb
);

    localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    apb_mst_state_e       state_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    apb_rsp_t             rsp_r;

    // Only IDLE can take a request, so at most one transfer is ever in flight.
    assign req_ready_o   = (state_r == IDLE);
    assign rsp_rdata_o   = rsp_r.rdata;
    assign rsp_err_o     = rsp_r.err;
    assign rsp_timeout_o = rsp_r.timeout;

    // Transfer FSM, stall counter and all registered bus/response outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_WIDTH{1'b0}};
            rsp_r       <= '{rdata: 32'h0000_0000, err: 1'b0, timeout: 1'b0};
            rsp_valid_o <= 1'b0;
            apb.PADDR   <= {APB_ADDR_WIDTH{1'b0}};
            apb.PWDATA  <= 32'h0000_0000;
            apb.PWRITE  <= 1'b0;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid_i) begin
                        apb.PADDR  <= {req_addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
                        apb.PWDATA <= req_wdata_i;
                        apb.PWRITE <= req_write_i;
                        apb.PSEL   <= 1'b1;
                        cnt_r      <= {CNT_WIDTH{1'b0}};
                        state_r    <= SETUP;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                SETUP: begin
                    apb.PENABLE <= 1'b1;
                    state_r     <= ACCESS;
                end
                ACCESS: begin
                    // A slave answering on the final allowed cycle still wins over the abort.
                    if (apb.PREADY) begin
                        rsp_r       <= apb_done_rsp(apb.PWRITE, apb.PRDATA, apb.PSLVERR);
                        rsp_valid_o <= 1'b1;
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        state_r     <= RESP;
                    end else if (TO_EN && (cnt_r == TO_LAST)) begin
                        rsp_r       <= apb_timeout_rsp();
                        rsp_valid_o <= 1'b1;
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        state_r     <= RESP;
                    end else begin
                        cnt_r       <= cnt_r + CNT_WIDTH'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        rsp_valid_o <= 1'b1;
                    end
                end
                default: begin
                    rsp_valid_o <= 1'b0;
                    apb.PSEL    <= 1'b0;
                    apb.PENABLE <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cfg_master.sv
// Self-checking bench: transaction-timeline model of the APB master, a randomized
// slave/requester, and directed scenarios pinned with literal expectations.
module tb_apb_cfg_master;

    localparam int AW = 12;
    localparam int TO = 8;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          req_valid_i, req_ready_o, req_write_i;
    logic [AW-1:0] req_addr_i;
    logic [31:0]   req_wdata_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
    logic [31:0]   rsp_rdata_o;

    apb_cfg_master_if #(.APB_ADDR_WIDTH(AW)) apb ();

    apb_cfg_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_write_i(req_write_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o), .apb(apb)
    );

    always #5 HCLK = ~HCLK;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: one transfer described by handshake cycle and completion cycle.
    bit          busy = 1'b0;
    int          n_hs = 0, c_done = 0, last_m = -100;
    int          cur_w = 0, cur_hold = 0;
    logic [31:0] cur_prd = 32'h0;
    bit          cur_err = 1'b0;
    logic [AW-1:0] e_paddr;
    logic [31:0] e_pwdata, e_rdata;
    bit          e_pwrite, e_err, e_to, tmo;
    bit          exp_psel, exp_pen, exp_rv;

    // Plan for the next request, snapshotted at its handshake.
    int          plan_w = 0, plan_hold = 0;
    logic [31:0] plan_prd = 32'h0;
    bit          plan_err = 1'b0;

    // Observations of the DUT, for literal checks after directed transfers.
    int            hs_count = 0, last_lat = 0, last_pen = 0, last_gap = 0;
    logic [31:0]   last_rdata;
    bit            last_err, last_to, prev_rv = 1'b0;
    logic [AW-1:0] last_paddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic drv_wait();
        @(posedge HCLK);
        #2;
    endtask

    // Cycle counter; inputs for cycle c are driven 2 units after posedge c.
    always @(posedge HCLK) cyc <= cyc + 1;

    // Compare process: checks every output each cycle, then advances the model.
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            busy = 1'b0;
            prev_rv = 1'b0;
            chk("rst_psel", 32'(apb.PSEL), 32'd0);
            chk("rst_penable", 32'(apb.PENABLE), 32'd0);
            chk("rst_pwrite", 32'(apb.PWRITE), 32'd0);
            chk("rst_paddr", 32'(apb.PADDR), 32'd0);
            chk("rst_pwdata", apb.PWDATA, 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
            chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
            chk("rst_rsp_timeout", 32'(rsp_timeout_o), 32'd0);
            chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        end else begin
            exp_psel = busy && (cyc >= n_hs + 1) && (cyc < c_done);
            exp_pen  = busy && (cyc >= n_hs + 2) && (cyc < c_done);
            exp_rv   = busy && (cyc >= c_done);
            chk("req_ready", 32'(req_ready_o), 32'(!busy));
            chk("psel", 32'(apb.PSEL), 32'(exp_psel));
            chk("penable", 32'(apb.PENABLE), 32'(exp_pen));
            chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_rv));
            if (exp_psel) begin
                chk("paddr", 32'(apb.PADDR), 32'(e_paddr));
                chk("pwdata", apb.PWDATA, e_pwdata);
                chk("pwrite", 32'(apb.PWRITE), 32'(e_pwrite));
            end
            if (exp_rv) begin
                chk("rsp_rdata", rsp_rdata_o, e_rdata);
                chk("rsp_err", 32'(rsp_err_o), 32'(e_err));
                chk("rsp_timeout", 32'(rsp_timeout_o), 32'(e_to));
            end
            if (apb.PENABLE) last_pen++;
            if (apb.PSEL) last_paddr = apb.PADDR;
            if (rsp_valid_o && !prev_rv) begin
                last_lat   = cyc - n_hs;
                last_rdata = rsp_rdata_o;
                last_err   = rsp_err_o;
                last_to    = rsp_timeout_o;
            end
            prev_rv = rsp_valid_o;
            if (exp_rv && rsp_ready_i) begin
                busy   = 1'b0;
                last_m = cyc;
            end else if (!busy && req_valid_i) begin
                busy     = 1'b1;
                n_hs     = cyc;
                last_gap = cyc - last_m;
                cur_w    = plan_w;
                cur_prd  = plan_prd;
                cur_err  = plan_err;
                cur_hold = plan_hold;
                e_paddr  = req_addr_i - (req_addr_i % AW'(4));
                e_pwdata = req_wdata_i;
                e_pwrite = req_write_i;
                tmo      = (plan_w >= TO);
                c_done   = n_hs + 2 + (tmo ? TO : plan_w + 1);
                e_rdata  = tmo ? 32'hDEAD0B0B : (req_write_i ? 32'h0 : plan_prd);
                e_err    = tmo ? 1'b1 : plan_err;
                e_to     = tmo;
                last_pen = 0;
                hs_count++;
            end
        end
    end

    // Slave and response-consumer: answers on the planned ACCESS cycle, noise elsewhere.
    always begin
        drv_wait();
        if (busy && HRESETn && (cyc >= n_hs + 2) && (cyc < c_done)) begin
            if (cyc - (n_hs + 2) == cur_w) begin
                apb.PREADY = 1'b1; apb.PRDATA = cur_prd; apb.PSLVERR = cur_err;
            end else begin
                apb.PREADY = 1'b0; apb.PRDATA = $urandom; apb.PSLVERR = 1'($urandom_range(0, 1));
            end
        end else begin
            apb.PREADY  = 1'($urandom_range(0, 1));
            apb.PRDATA  = $urandom;
            apb.PSLVERR = 1'($urandom_range(0, 1));
        end
        if (busy && HRESETn && (cyc >= c_done))
            rsp_ready_i = (cyc - c_done >= cur_hold);
        else
            rsp_ready_i = 1'($urandom_range(0, 1));
    end

    task automatic send(input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                        input int w, input logic [31:0] prd, input bit e, input int hold);
        int hc;
        hc = hs_count;
        plan_w = w; plan_prd = prd; plan_err = e; plan_hold = hold;
        req_valid_i = 1'b1; req_write_i = wr; req_addr_i = a; req_wdata_i = wd;
        for (int i = 0; i < 200 && hs_count == hc; i++) drv_wait();
        chk("req_accepted", 32'(hs_count != hc), 32'd1);
        req_valid_i = 1'b0;
        req_addr_i  = AW'($urandom);
        req_wdata_i = $urandom;
        req_write_i = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy; i++) drv_wait();
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        int r, w;
        HRESETn = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; req_write_i = 1'b0;
        rsp_ready_i = 1'b0; apb.PREADY = 1'b0; apb.PRDATA = '0; apb.PSLVERR = 1'b0;
        repeat (3) @(posedge HCLK);
        #2;
        HRESETn = 1'b1;

        send(1'b1, 12'h004, 32'h1A000100, 0, 32'h5555AAAA, 1'b0, 0);
        wait_idle();
        chk("wr_lat", 32'(last_lat), 32'd3);
        chk("wr_rdata", last_rdata, 32'd0);
        chk("wr_err", 32'(last_err), 32'd0);
        chk("wr_paddr", 32'(last_paddr), 32'h004);
        chk("wr_pen_cycles", 32'(last_pen), 32'd1);

        send(1'b0, 12'h0A0, 32'h0, 3, 32'hCAFE0001, 1'b0, 1);
        wait_idle();
        chk("rd_lat", 32'(last_lat), 32'd6);
        chk("rd_rdata", last_rdata, 32'hCAFE0001);
        chk("rd_pen_cycles", 32'(last_pen), 32'd4);

        send(1'b0, 12'h3FC, 32'h0, 0, 32'hDEADBEEF, 1'b1, 0);
        wait_idle();
        chk("slverr_err", 32'(last_err), 32'd1);
        chk("slverr_to", 32'(last_to), 32'd0);
        chk("slverr_rdata", last_rdata, 32'hDEADBEEF);

        send(1'b0, 12'h010, 32'h0, 1000, 32'h0, 1'b0, 2);
        wait_idle();
        chk("to_pen_cycles", 32'(last_pen), 32'd8);
        chk("to_lat", 32'(last_lat), 32'd10);
        chk("to_rdata", last_rdata, 32'hDEAD0B0B);
        chk("to_err", 32'(last_err), 32'd1);
        chk("to_flag", 32'(last_to), 32'd1);

        send(1'b0, 12'h020, 32'h0, 7, 32'h12345678, 1'b0, 0);
        wait_idle();
        chk("lastcyc_to", 32'(last_to), 32'd0);
        chk("lastcyc_rdata", last_rdata, 32'h12345678);
        chk("lastcyc_pen", 32'(last_pen), 32'd8);

        send(1'b1, 12'h040, 32'hA5A5A5A5, 0, 32'h0, 1'b0, 5);
        send(1'b1, 12'h044, 32'h5A5A5A5A, 0, 32'h0, 1'b0, 0);
        chk("b2b_gap", 32'(last_gap), 32'd1);
        wait_idle();

        send(1'b0, 12'h100, 32'h0, 20, 32'h0, 1'b0, 0);
        drv_wait();
        HRESETn = 1'b0;
        #1;
        chk("async_psel", 32'(apb.PSEL), 32'd0);
        chk("async_penable", 32'(apb.PENABLE), 32'd0);
        chk("async_rsp_valid", 32'(rsp_valid_o), 32'd0);
        drv_wait();
        drv_wait();
        HRESETn = 1'b1;
        send(1'b0, 12'h007, 32'h0, 1, 32'h0BADF00D, 1'b0, 0);
        wait_idle();
        chk("align_paddr", 32'(last_paddr), 32'h004);
        chk("post_rst_lat", 32'(last_lat), 32'd4);
        chk("post_rst_rdata", last_rdata, 32'h0BADF00D);

        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      w = $urandom_range(0, 3);
            else if (r == 6) w = $urandom_range(6, 7);
            else if (r == 7) w = TO;
            else if (r == 8) w = 50;
            else             w = 0;
            send(1'($urandom_range(0, 1)), AW'($urandom), $urandom, w, $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) wait_idle();
            repeat ($urandom_range(0, 2)) drv_wait();
        end
        wait_idle();
        repeat (2) drv_wait();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
